// File: rtl/fb_pkg.sv
// Shared constants for the camera frame-buffer write path.
// Holds the buffer geometry, the RGB565 field widths and the scheduler FSM encoding.
package fb_pkg;

  localparam int W     = 160;
  localparam int H     = 120;
  localparam int AW    = 15;
  localparam int R_W   = 5;
  localparam int G_W   = 6;
  localparam int B_W   = 5;
  localparam int PIX_W = R_W + G_W + B_W;
  localparam int POS_W = 10;

  localparam logic [1:0] WAIT_SOF   = 2'd0;
  localparam logic [1:0] CAPTURE    = 2'd1;
  localparam logic [1:0] FRAME_DONE = 2'd2;

endpackage

// File: rtl/sync_edge_detect.sv
// Keeps the previous level of a signal and emits one-cycle rise/fall pulses.
// Ports: clk, reset (async high), level in; rise, fall out.
module sync_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise,
  output logic fall
);

  logic prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev <= 1'b0;
    else       prev <= level;
  end

  assign rise = level & ~prev;
  assign fall = ~level & prev;

endmodule

// File: rtl/fb_write_scheduler.sv
// Decimates the camera pixel stream into linear frame-buffer writes and ping-pongs banks.
// Ports: camera vsync/pixel in, freeze, display vsync; write port, banks, counters, busy out.
module fb_write_scheduler
  import fb_pkg::*;
#(
  parameter int W         = fb_pkg::W,
  parameter int H         = fb_pkg::H,
  parameter int DEC_SHIFT = 2,
  parameter int MIRROR_X  = 1,
  parameter int AW        = fb_pkg::AW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cam_vsync,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_data,
  input  logic [POS_W-1:0] pix_row,
  input  logic [POS_W-1:0] pix_col,
  input  logic             freeze,
  input  logic             disp_vsync,
  output logic             we,
  output logic [AW-1:0]    waddr,
  output logic [PIX_W-1:0] wdata,
  output logic             wbank,
  output logic             rbank,
  output logic [7:0]       frame_count,
  output logic [7:0]       drop_count,
  output logic             busy
);

  localparam logic [POS_W-1:0] DMASK =
    POS_W'((1 << DEC_SHIFT) - 1);
  localparam logic [POS_W-1:0] W_P = POS_W'(W);
  localparam logic [POS_W-1:0] H_P = POS_W'(H);

  logic [1:0] state;
  logic       pending;
  logic       sof;
  logic       eof;
  logic       dswap;
  logic       unused_disp_fall;

  sync_edge_detect u_cam_ed (
    .clk   (clk),
    .reset (reset),
    .level (cam_vsync),
    .rise  (eof),
    .fall  (sof)
  );

  sync_edge_detect u_disp_ed (
    .clk   (clk),
    .reset (reset),
    .level (disp_vsync),
    .rise  (dswap),
    .fall  (unused_disp_fall)
  );

  logic [POS_W-1:0] x;
  logic [POS_W-1:0] y;
  logic [POS_W-1:0] xs;
  logic [AW-1:0]    y_a;
  logic [AW-1:0]    y_mul;
  logic [AW-1:0]    addr_n;
  logic             accept;

  assign x  = pix_col >> DEC_SHIFT;
  assign y  = pix_row >> DEC_SHIFT;
  assign xs = (MIRROR_X != 0) ? (W_P - 10'd1 - x) : x;

  assign y_a   = AW'(y);
  // 160 = 128 + 32, so the stride multiply is two shifts and an add
  assign y_mul = (W == 160) ? ((y_a << 7) + (y_a << 5))
                            : (y_a * AW'(W));
  assign addr_n = y_mul + AW'(xs);

  assign accept = (state == CAPTURE) & pix_valid
                & ((pix_row & DMASK) == '0)
                & ((pix_col & DMASK) == '0)
                & (x < W_P) & (y < H_P);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= WAIT_SOF;
      frame_count <= 8'd0;
      drop_count  <= 8'd0;
    end else begin
      unique case (1'b1)
        (state == WAIT_SOF): begin
          if (sof) begin
            if (pending)      drop_count <= drop_count + 8'd1;
            else if (!freeze) state      <= CAPTURE;
          end
        end
        (state == CAPTURE): begin
          if (eof) state <= FRAME_DONE;
        end
        (state == FRAME_DONE): begin
          frame_count <= frame_count + 8'd1;
          state       <= WAIT_SOF;
        end
        default: state <= WAIT_SOF;
      endcase
    end
  end

  // pending is 0 throughout FRAME_DONE, so a coincident dswap
  // cannot swap; the swap waits for the next display edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= 1'b0;
      wbank   <= 1'b0;
    end else begin
      if (dswap && pending) begin
        wbank   <= ~wbank;
        pending <= 1'b0;
      end
      if (state == FRAME_DONE) pending <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we    <= 1'b0;
      waddr <= '0;
      wdata <= '0;
    end else begin
      we <= accept;
      if (accept) begin
        waddr <= addr_n;
        wdata <= pix_data;
      end
    end
  end

  assign rbank = ~wbank;
  assign busy  = (state == CAPTURE);

endmodule

// File: tb/tb_fb_write_scheduler.sv
// Scoreboard bench for fb_write_scheduler.
// Directed frames cover mapping, decimation, banking, drops and freeze.
module tb_fb_write_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        cam_vsync;
  logic        pix_valid;
  logic [15:0] pix_data;
  logic [9:0]  pix_row;
  logic [9:0]  pix_col;
  logic        freeze;
  logic        disp_vsync;
  logic        we;
  logic [14:0] waddr;
  logic [15:0] wdata;
  logic        wbank;
  logic        rbank;
  logic [7:0]  frame_count;
  logic [7:0]  drop_count;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [14:0] addr;
    logic [15:0] data;
    logic        bank;
  } wr_t;

  wr_t exp_q[$];

  fb_write_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .cam_vsync   (cam_vsync),
    .pix_valid   (pix_valid),
    .pix_data    (pix_data),
    .pix_row     (pix_row),
    .pix_col     (pix_col),
    .freeze      (freeze),
    .disp_vsync  (disp_vsync),
    .we          (we),
    .waddr       (waddr),
    .wdata       (wdata),
    .wbank       (wbank),
    .rbank       (rbank),
    .frame_count (frame_count),
    .drop_count  (drop_count),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_we: addr %0d data %0h",
                 waddr, wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("waddr", 32'(waddr), 32'(e.addr));
        chk("wdata", 32'(wdata), 32'(e.data));
        chk("wbank", 32'(wbank), 32'(e.bank));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input logic [9:0] r,
                     input logic [9:0] c,
                     input logic [15:0] d,
                     input bit keep,
                     input logic [14:0] a,
                     input logic b);
    pix_valid = 1'b1;
    pix_row   = r;
    pix_col   = c;
    pix_data  = d;
    if (keep) exp_q.push_back('{addr: a, data: d, bank: b});
    tick();
    pix_valid = 1'b0;
  endtask

  task automatic cam(input logic l);
    cam_vsync = l;
    tick();
  endtask

  task automatic disp(input logic l);
    disp_vsync = l;
    tick();
  endtask

  initial begin
    reset      = 1'b1;
    cam_vsync  = 1'b1;
    pix_valid  = 1'b0;
    pix_data   = '0;
    pix_row    = '0;
    pix_col    = '0;
    freeze     = 1'b0;
    disp_vsync = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_we", 32'(we), 0);
    chk("rst_waddr", 32'(waddr), 0);
    chk("rst_wdata", 32'(wdata), 0);
    chk("rst_wbank", 32'(wbank), 0);
    chk("rst_rbank", 32'(rbank), 1);
    chk("rst_fc", 32'(frame_count), 0);
    chk("rst_dc", 32'(drop_count), 0);
    chk("rst_busy", 32'(busy), 0);

    // frame 1: mapping, decimation, range, reset in flight
    cam(1'b1);
    cam(1'b0);
    chk("cap_busy", 32'(busy), 1);
    pix(10'd8, 10'd12, 16'hF800, 1, 15'd476, 1'b0);
    pix(10'd0, 10'd13, 16'h1111, 0, '0, 1'b0);
    pix(10'd480, 10'd0, 16'h2222, 0, '0, 1'b0);
    pix(10'd0, 10'd636, 16'h07E0, 1, 15'd0, 1'b0);
    pix(10'd4, 10'd4, 16'h3333, 0, '0, 1'b0);
    reset = 1'b1;
    tick();
    chk("mrst_we", 32'(we), 0);
    chk("mrst_busy", 32'(busy), 0);
    reset = 1'b0;

    // frame 2: eof with a same-cycle pixel, then swaps
    cam(1'b1);
    cam(1'b0);
    pix(10'd0, 10'd0, 16'h1234, 1, 15'd159, 1'b0);
    cam_vsync = 1'b1;
    pix(10'd4, 10'd8, 16'hABCD, 1, 15'd317, 1'b0);
    tick();
    chk("f2_fc", 32'(frame_count), 1);
    chk("f2_wbank", 32'(wbank), 0);
    disp(1'b1);
    chk("sw1_wbank", 32'(wbank), 1);
    chk("sw1_rbank", 32'(rbank), 0);
    disp(1'b0);
    disp(1'b1);
    chk("sw2_wbank", 32'(wbank), 1);
    disp(1'b0);

    // frame 3: FRAME_DONE coincides with dswap
    cam(1'b0);
    pix(10'd0, 10'd4, 16'h5555, 1, 15'd158, 1'b1);
    cam(1'b1);
    disp(1'b1);
    chk("sim_wbank", 32'(wbank), 1);
    chk("sim_fc", 32'(frame_count), 2);
    disp(1'b0);
    disp(1'b1);
    chk("sim2_wbank", 32'(wbank), 0);
    chk("sim2_rbank", 32'(rbank), 1);
    disp(1'b0);

    // frames 4/5: pending swap blocks the second frame
    cam(1'b0);
    pix(10'd0, 10'd0, 16'h6666, 1, 15'd159, 1'b0);
    cam(1'b1);
    tick();
    chk("pa_fc", 32'(frame_count), 3);
    cam(1'b0);
    chk("pb_dc", 32'(drop_count), 1);
    chk("pb_busy", 32'(busy), 0);
    pix(10'd0, 10'd0, 16'h7777, 0, '0, 1'b0);
    cam(1'b1);
    tick();
    chk("pb_fc", 32'(frame_count), 3);
    disp(1'b1);
    chk("pb_wbank", 32'(wbank), 1);
    disp(1'b0);

    // freeze at sof, then freeze mid-frame
    freeze = 1'b1;
    cam(1'b0);
    chk("fz_busy", 32'(busy), 0);
    chk("fz_dc", 32'(drop_count), 1);
    pix(10'd0, 10'd0, 16'h8888, 0, '0, 1'b0);
    cam(1'b1);
    freeze = 1'b0;
    cam(1'b0);
    chk("fz2_busy", 32'(busy), 1);
    freeze = 1'b1;
    pix(10'd8, 10'd0, 16'h9999, 1, 15'd479, 1'b1);
    cam(1'b1);
    tick();
    chk("fz2_fc", 32'(frame_count), 4);
    freeze = 1'b0;

    repeat (4) tick();
    chk("q_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/fb_write_scheduler.md
Name: fb_write_scheduler

Overview:
- Sequences camera pixel writes into the 160x120 RGB565 frame buffer and owns ping-pong bank selection between capture and display.
- Sits between the camera capture block (pixel stream with row/col) and the dual-bank buffer write port. Its inputs are already synchronised into clk.
- Decimates the stream, generates linear write addresses, gates whole frames, and swaps banks only on display vsync after a complete capture.

Parameters:
- W, 160, buffer width in pixels (address stride)
- H, 120, buffer height in lines
- DEC_SHIFT, 2, decimation: keep pixel when row and col low DEC_SHIFT bits are all zero
- MIRROR_X, 1, 1: x stored as W-1-x
- AW, 15, write address width; ceil(log2(W*H)) must be <= AW

Ports:
- clk  in  1  pixel-domain clock
- reset  in  1  asynchronous, active-high
- cam_vsync  in  1  camera vsync level, high during camera vertical blank
- pix_valid  in  1  one-cycle strobe, pixel word valid
- pix_data  in  16  RGB565 pixel
- pix_row  in  10  camera line index of pixel
- pix_col  in  10  camera pixel index within line
- freeze  in  1  1 = hold current image (no new frame starts)
- disp_vsync  in  1  display vsync level, rising edge = display frame boundary
- we  out  1  buffer write enable
- waddr  out  AW  buffer address within bank
- wdata  out  16  buffer write data
- wbank  out  1  bank being written
- rbank  out  1  bank being displayed, always ~wbank
- frame_count  out  8  completed captured frames, wraps 255->0
- drop_count  out  8  camera frames skipped because pending swap not consumed, wraps
- busy  out  1  1 while in CAPTURE

Behaviour:
- Reset (async): state=WAIT_SOF, we=0, waddr=0, wdata=0, wbank=0, rbank=1, pending=0, frame_count=0, drop_count=0, busy=0, edge-detect registers=0.
- Edge detect: registered previous cam_vsync/disp_vsync. sof = fall of cam_vsync; eof = rise of cam_vsync; dswap = rise of disp_vsync.
- FSM WAIT_SOF: on sof and freeze=0 and pending=0 -> CAPTURE. On sof and pending=1 -> drop_count+1, stay in WAIT_SOF. On sof and freeze=1 -> stay, no count. A partial frame after reset is never captured.
- FSM CAPTURE: busy=1. Pixel accepted when pix_valid=1, low DEC_SHIFT bits of row and col are 0, x=col>>DEC_SHIFT < W, and y=row>>DEC_SHIFT < H. Out-of-range pixels are silently dropped. freeze is ignored mid-frame. On eof -> FRAME_DONE.
- FSM FRAME_DONE (1 cycle): pending=1, frame_count+1 -> WAIT_SOF.
- Address: xs = MIRROR_X ? W-1-x : x; waddr = y*W + xs. For W=160, compute y*W as (y<<7)+(y<<5). Result is truncated to AW bits.
- Latency: accepted pixel in cycle N gives we=1, waddr and wdata registered in cycle N+1. we=0 in every other cycle. No backpressure; the buffer accepts one write per cycle.
- pix_valid in the same cycle as eof is still accepted.
- Swap: on dswap with pending=1: wbank<=~wbank, rbank<=~rbank, pending<=0.
- Simultaneous FRAME_DONE and dswap: pending is set this cycle and the swap occurs at the next dswap.
- sof on the cycle after a same-cycle swap sees pending=0 and captures.
- dswap with pending=0: no change.
- Reset mid-frame: immediate return to reset values. The in-flight write is lost and no we is issued.

Decomposition:
- Shared package fb_pkg holds: W, H, AW, RGB565 field widths, FSM state encoding (WAIT_SOF=2'd0, CAPTURE=2'd1, FRAME_DONE=2'd2).
- One sub-module, sync_edge_detect, holds the previous-level register and emits one-cycle rise/fall pulses. It is instantiated twice, for cam_vsync and disp_vsync.

Test Plan:
- Reset, then a full frame: toggle cam_vsync 1->0, then pixel at row=8, col=12 with data 16'hF800, MIRROR_X=1 -> next cycle we=1, waddr=2*160+(159-3)=476, wdata=16'hF800, wbank=0. Mid-frame reset then drops it.
- Decimation/range: pixels at col=13 and row=480 -> no we. Pixel at col=636, row=0 -> x=159 -> waddr=0.
- Frame end then dswap: eof -> frame_count=1 with pending set. Next disp_vsync rise -> wbank=1, rbank=0. A second dswap with no new frame -> no change.
- Simultaneous: FRAME_DONE cycle coincides with dswap -> banks unchanged that cycle; they swap on the following disp_vsync rise.
- Pending blocks capture: two camera frames with no disp_vsync -> second sof gives drop_count=1, busy stays 0, and no we for that frame.
- Freeze: freeze=1 at sof -> no capture and drop_count unchanged. freeze raised mid-frame -> frame completes and frame_count increments.
